// File: rtl/btn_tx_scheduler.sv
// Round-robin scheduler that turns button pulses into bytes on a shared UART transmitter.
// Optional build macro BTN_TX_CRLF_EN: every granted byte is followed by 8'h0D and 8'h0A.
module btn_tx_scheduler #(
  parameter int          N_BTN       = 4,
  parameter logic [7:0]  CHAR_BASE   = 8'h41,
  parameter int          ACK_TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BTN-1:0]  btn_pulse,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [N_BTN-1:0]  pending,
  output logic [7:0]        drop_cnt,
  output logic              ack_err,
  output logic [1:0]        dbg_state
);

  localparam int PW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;

  // Transmitter handshake: tx_start is a one-cycle strobe with tx_data valid in the
  // same cycle; the transmitter acknowledges by raising tx_busy and releases the
  // channel by dropping it once the stop bit has gone out.
  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_inc;
  logic [CW-1:0]   to_cnt;
  logic            at_limit;
  logic            timeout_hit;
  logic            grant_valid;
  logic            do_grant;
  logic [PW-1:0]   grant_idx;
  logic [N_BTN-1:0] grant_mask;
  logic [PW:0]     cand;
  logic [N_BTN-1:0] pend_nxt;
  logic [N_BTN-1:0] drop_bits;
  logic [3:0]      drop_inc;
  logic [8:0]      drop_sum;
  logic [7:0]      drop_nxt;
`ifdef BTN_TX_CRLF_EN
  logic [1:0]      phase;
  logic            seq_next;
`endif

  assign tx_start  = (state == START);
  assign dbg_state = state;
  assign at_limit  = (to_cnt == CW'(ACK_TIMEOUT - 1));

  // Search from ptr upward, wrapping, for the first pending requester.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N_BTN; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(N_BTN)) cand = cand - (PW+1)'(N_BTN);
      if (!grant_valid && pending[cand[PW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[PW-1:0];
      end
    end
  end

  assign do_grant = (state == IDLE) && grant_valid;
  assign ptr_inc  = (grant_idx == PW'(N_BTN - 1)) ? '0 : grant_idx + PW'(1);

  // A pulse landing on its own grant cycle re-arms the bit and is not a drop.
  always_comb begin
    grant_mask = '0;
    if (do_grant) grant_mask[grant_idx] = 1'b1;
    pend_nxt  = (pending & ~grant_mask) | btn_pulse;
    drop_bits = btn_pulse & pending & ~grant_mask;
    drop_inc  = '0;
    for (int i = 0; i < N_BTN; i++) drop_inc = drop_inc + {3'b000, drop_bits[i]};
    drop_sum = {1'b0, drop_cnt} + {5'b00000, drop_inc};
    drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
`ifdef BTN_TX_CRLF_EN
    seq_next    = 1'b0;
`endif
    case (state)
      IDLE:      if (grant_valid) state_nxt = START;
      START:     state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (at_limit) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef BTN_TX_CRLF_EN
          if (phase != 2'd2) begin
            seq_next  = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
`else
          state_nxt = IDLE;
`endif
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= '0;
      drop_cnt <= '0;
      ack_err  <= 1'b0;
      tx_data  <= '0;
      ptr      <= '0;
      to_cnt   <= '0;
`ifdef BTN_TX_CRLF_EN
      phase    <= '0;
`endif
    end else begin
      state    <= state_nxt;
      pending  <= pend_nxt;
      drop_cnt <= drop_nxt;
      if (do_grant) begin
        tx_data <= CHAR_BASE + 8'(grant_idx);
        ptr     <= ptr_inc;
`ifdef BTN_TX_CRLF_EN
        phase   <= '0;
`endif
      end
      if (state == START) begin
        to_cnt <= '0;
      end else if (state == WAIT_ACK && !tx_busy && !at_limit) begin
        to_cnt <= to_cnt + CW'(1);
      end
      if (timeout_hit) ack_err <= 1'b1;
`ifdef BTN_TX_CRLF_EN
      // Trailer bytes follow the granted byte; a timeout drops back to IDLE instead.
      if (seq_next) begin
        phase   <= phase + 2'd1;
        tx_data <= (phase == 2'd0) ? 8'h0D : 8'h0A;
      end
`endif
    end
  end

endmodule

// File: tb/tb_btn_tx_scheduler.sv
// Bench for btn_tx_scheduler: directed scenarios plus random pulses, scored against
// a cycle-stepped reference of pending set, round-robin order and transfer timing.
module tb_btn_tx_scheduler;

  localparam int         N  = 4;
  localparam logic [7:0] CB = 8'h41;
  localparam int         TO = 1000;
  localparam int         W  = 40;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_pulse = '0;
  logic         tx_busy = 1'b0;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic [N-1:0] pending;
  logic [7:0]   drop_cnt;
  logic         ack_err;
  logic [1:0]   dbg_state;

  btn_tx_scheduler #(.N_BTN(N), .CHAR_BASE(CB), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .btn_pulse(btn_pulse), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .pending(pending),
    .drop_cnt(drop_cnt), .ack_err(ack_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle index
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];   // {start cycle[31:0], byte[7:0]}
  logic [W-1:0] mon_e;

  // ---------------- reference model state
  logic [N-1:0] m_pend;
  int  m_ptr, m_drop, m_next_idle, m_ack_at, m_ack_exp;
  bit  m_timeout = 1'b0;
  bit  xmit_en   = 1'b1;
  int  busy_len  = 10;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_ptr = 0; m_drop = 0; m_next_idle = 0;
    m_ack_at = 32'h7fffffff; m_ack_exp = 0;
    exp_q.delete();
  endtask

  // One clock of behaviour: grant from the current pending set, then apply pulses.
  task automatic model_cycle(input logic [N-1:0] p, input int c);
    int g = -1;
    int nbytes = 1;
    if (c >= m_next_idle && m_pend != '0) begin
      for (int k = 0; k < N; k++) begin
        int idx = (m_ptr + k) % N;
        if (g < 0 && m_pend[idx]) g = idx;
      end
      exp_q.push_back({32'(c + 1), 8'(CB + g)});
`ifdef BTN_TX_CRLF_EN
      if (!m_timeout) begin
        exp_q.push_back({32'(c + 1 + (busy_len + 2)), 8'h0D});
        exp_q.push_back({32'(c + 1 + 2 * (busy_len + 2)), 8'h0A});
        nbytes = 3;
      end
`endif
      m_ptr = (g + 1) % N;
      m_pend[g] = 1'b0;
      if (m_timeout) begin
        m_next_idle = c + TO + 2;
        if (m_ack_at > c + TO + 2) m_ack_at = c + TO + 2;
      end else begin
        m_next_idle = c + 1 + nbytes * (busy_len + 2);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (p[i]) begin
        if (m_pend[i] && m_drop < 255) m_drop++;
        m_pend[i] = 1'b1;
      end
    end
    m_ack_exp = (c + 1 >= m_ack_at) ? 1 : 0;
  endtask

  // ---------------- driver
  task automatic step(input logic [N-1:0] p);
    int c;
    btn_pulse = p;
    @(posedge clk);
    c = cyc;
    model_cycle(p, c);
    #1;
    btn_pulse = '0;
    chk("pending", int'(pending), int'(m_pend));
    chk("drop_cnt", int'(drop_cnt), m_drop);
    chk("ack_err", int'(ack_err), m_ack_exp);
  endtask

  task automatic drain();
    int n = 0;
    while ((cyc < m_next_idle + 2 || m_pend != '0 || exp_q.size() != 0) && n < 5000) begin
      step('0);
      n++;
    end
    chk("drain_bound", (n < 5000) ? 1 : 0, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_tx_start"}, int'(tx_start), 0);
    chk({tag, "_tx_data"}, int'(tx_data), 0);
    chk({tag, "_pending"}, int'(pending), 0);
    chk({tag, "_drop_cnt"}, int'(drop_cnt), 0);
    chk({tag, "_ack_err"}, int'(ack_err), 0);
  endtask

  // ---------------- transmitter model: busy rises the cycle after tx_start
  initial forever begin
    @(negedge clk);
    if (rst_n && tx_start && xmit_en) begin
      @(posedge clk);
      #1 tx_busy = 1'b1;
      repeat (busy_len) @(posedge clk);
      #1 tx_busy = 1'b0;
    end
  end

  // ---------------- monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (rst_n && tx_start) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_start got=%0h exp=none (cycle %0d)", tx_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tx_data", int'(tx_data), int'(mon_e[7:0]));
        chk("start_cycle", cyc, int'(mon_e[39:8]));
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus
  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // single request
    step(4'b0001);
    drain();

    // simultaneous requests, then pointer wrap
    step(4'b1011);
    drain();
    step(4'b0001);
    drain();

    // drops while busy
    step(4'b0001);
    repeat (4) step('0);
    step(4'b0100);
    step('0);
    step(4'b0100);
    step(4'b0100);
    chk("drop_cnt_after_three", int'(drop_cnt), 2);
    chk("pending2_set", int'(pending[2]), 1);
    drain();

    // pulse on the grant cycle of the same bit
    step(4'b0010);
    step(4'b0010);
    chk("setwins_pending1", int'(pending[1]), 1);
    chk("setwins_drop_cnt", int'(drop_cnt), 2);
    drain();

    // acknowledge timeout, then the next pending request is still served
    xmit_en = 1'b0;
    m_timeout = 1'b1;
    step(4'b0001);
    repeat (5) step('0);
    step(4'b0100);
    drain();
    chk("timeout_ack_err", int'(ack_err), 1);
    xmit_en = 1'b1;
    m_timeout = 1'b0;

    // reset in the middle of a transfer with requests queued
    step(4'b0001);
    repeat (3) step('0);
    step(4'b1100);
    step('0);
    chk("pre_reset_pending", int'(pending), 4'b1100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) step('0);

    // random traffic in phases with a fixed transmitter busy time each
    for (int ph = 0; ph < 4; ph++) begin
      busy_len = $urandom_range(1, 12);
      for (int t = 0; t < 150; t++) begin
        if ($urandom_range(0, 3) == 0) step(N'($urandom_range(0, 15)));
        else step('0);
      end
      drain();
    end

    chk("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_tx_scheduler.md
Name: btn_tx_scheduler

Overview:
- Arbitrates single-cycle button pulses from N debounce stages onto one shared UART transmitter.
- Each button maps to one ASCII byte (CHAR_BASE + index).
- Latches requests and grants them round-robin.
- Sequences the transmitter handshake (tx_start / tx_busy) so no request is lost while a byte is in flight.

Parameters:
- N_BTN, 4, number of button requesters (2..8).
- CHAR_BASE, 8'h41, byte sent for button 0; button i sends CHAR_BASE+i (8-bit wrap).
- ACK_TIMEOUT, 1000, max cycles to wait for tx_busy to rise after tx_start.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_pulse  in  N_BTN  one-cycle rising-edge pulses, one bit per button.
- tx_busy  in  1  transmitter busy; high from accept until stop bit completes.
- tx_start  out  1  one-cycle send strobe.
- tx_data  out  8  byte to send; valid while tx_start=1, held until next grant.
- pending  out  N_BTN  latched, not-yet-granted requests.
- drop_cnt  out  8  saturating count of pulses arriving on an already-pending bit.
- ack_err  out  1  sticky: a tx_start timed out without tx_busy.

Behaviour:
- Reset: already decided — reset rst_n, asynchronous, active-low; clock clk. All outputs reset to 0; FSM = IDLE; RR pointer = 0.
- Request latch, per bit i, evaluated each cycle:
  - btn_pulse[i]=1 and pending[i]=0 → set pending[i].
  - btn_pulse[i]=1 and pending[i]=1 and bit not being granted this cycle → drop_cnt+1, saturating at 255.
  - Pulse in the same cycle as grant of bit i → pending[i] stays 1 (set wins over clear); not counted as a drop.
- Arbitration:
  - Round-robin starting at ptr; ptr = granted index + 1, wrapping at N_BTN.
  - With no pending bits, ptr does not move.
- FSM states: IDLE, START, WAIT_ACK, WAIT_DONE.
  - IDLE: if any pending bit → pick winner g, load tx_data = CHAR_BASE+g, clear pending[g], advance ptr → START.
  - START: tx_start=1 for exactly one cycle; clear timeout counter → WAIT_ACK.
  - WAIT_ACK:
    - tx_busy=1 → WAIT_DONE.
    - Counter reaches ACK_TIMEOUT-1 → set ack_err, → IDLE. The byte is abandoned, not re-queued.
  - WAIT_DONE: tx_busy=0 → IDLE.
- Latency: a pulse into an idle block with nothing pending gives tx_start exactly 2 cycles later (latch cycle, IDLE grant cycle, then START).
- Back-to-back: the next grant occurs in the IDLE cycle after tx_busy falls; minimum 3 cycles between tx_start pulses plus transmitter busy time.
- tx_busy already high while in IDLE: no effect; a grant still issues, and WAIT_ACK sees busy at once. The transmitter is responsible for ignoring starts while busy.
- ack_err clears only on reset.
- Reset mid-transfer: FSM returns to IDLE; pending, drop_cnt and ack_err are cleared; tx_start deasserts immediately.

Optional Feature:
- BTN_TX_CRLF_EN defined: after each granted byte completes (WAIT_DONE exit), send 8'h0D then 8'h0A.
  - Each of these bytes goes through its own START / WAIT_ACK / WAIT_DONE.
  - No arbitration until the 0x0A byte completes.
  - A timeout on any of the three bytes aborts the rest of the sequence and sets ack_err.
- Undefined: single byte per grant; no CR/LF states synthesized.

Test Plan:
- Single request: pulse btn_pulse=4'b0001, with a transmitter model that raises tx_busy 1 cycle after tx_start for 10 cycles → tx_start once, 2 cycles after the pulse; tx_data=8'h41; pending returns to 0.
- Simultaneous requests: pulse 4'b1011 in one cycle → bytes sent in order 0x41, 0x42, 0x44; then pulse 4'b0001 → 0x41 (ptr had wrapped to 0).
- Drops: hold a transmission busy; pulse bit 2 three times → pending[2]=1, drop_cnt=2, exactly one 0x43 sent.
- Set-wins race: pulse bit 1 in the exact IDLE grant cycle of bit 1 → pending[1] stays 1, drop_cnt unchanged, two 0x42 bytes sent.
- Timeout: tx_busy tied 0 with ACK_TIMEOUT=1000 → ack_err=1 1000 cycles after tx_start; FSM back in IDLE; the next pending request is still served.
- Reset mid-transfer: assert rst_n=0 during WAIT_DONE with pending=4'b1100 → all outputs 0 immediately; no tx_start after release until a new pulse arrives.
  - With BTN_TX_CRLF_EN defined, a single pulse on bit 0 gives the sequence 0x41, 0x0D, 0x0A.
